// File: rtl/sale_pkg.sv
// Shared encodings for the sale terminal: FSM states, direction codes and button vector layout.
package sale_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PAY      = 3'd1,
    ST_DISPENSE = 3'd2,
    ST_CHANGE   = 3'd3,
    ST_REFUND   = 3'd4
  } state_e;

  localparam logic [1:0] DIR_LEFT  = 2'b00;
  localparam logic [1:0] DIR_UP    = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam int NUM_PROD_DEF = 12;

  // Bit positions inside the 6-bit debounced button vector.
  localparam int BTN_IDX_R      = 0;
  localparam int BTN_IDX_D      = 1;
  localparam int BTN_IDX_U      = 2;
  localparam int BTN_IDX_L      = 3;
  localparam int BTN_IDX_BUY    = 4;
  localparam int BTN_IDX_CANCEL = 5;
  localparam int BTN_NUM        = 6;

endpackage

// File: rtl/btn_edge_detect.sv
// Registered rising-edge detector; history is loaded with the live levels during reset so that
// buttons already held when reset releases never produce a pulse.
module btn_edge_detect #(
  parameter int W = 6
) (
  input  logic         CLOCK,
  input  logic         RESET_N,
  input  logic [W-1:0] btn_i,
  output logic [W-1:0] pulse_o
);

  logic [W-1:0] prev_q;
  logic [W-1:0] pulse_q;

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      prev_q  <= btn_i;
      pulse_q <= '0;
    end else begin
      prev_q  <= btn_i;
      pulse_q <= btn_i & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/sale_sequencer.sv
// Sale terminal transaction controller: button arbitration, navigation gating and the
// buy/pay/dispense/change/refund flow with credit accounting and PAY inactivity timeout.
//
// state    | meaning
// IDLE     | browsing; navigation, coins, BUY and CANCEL accepted
// PAY      | product latched, waiting for enough credit; timeout refunds
// DISPENSE | one cycle, DISPENSE strobe with latched ID
// CHANGE   | one cycle, change strobe if credit exceeds price; credit cleared
// REFUND   | one cycle, full credit returned; credit cleared
module sale_sequencer
  import sale_pkg::*;
#(
  parameter int CREDIT_W    = 8,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int NUM_PROD    = NUM_PROD_DEF
) (
  input  logic                CLOCK,
  input  logic                RESET_N,
  input  logic                BTN_L,
  input  logic                BTN_U,
  input  logic                BTN_D,
  input  logic                BTN_R,
  input  logic                BTN_BUY,
  input  logic                BTN_CANCEL,
  input  logic                COIN_VALID,
  input  logic [CREDIT_W-1:0] COIN_VALUE,
  input  logic [3:0]          PRODUCT_ID,
  input  logic [CREDIT_W-1:0] PRICE,
  input  logic                STOCK_OK,
  output logic [1:0]          DIR_OUT,
  output logic                NAV_EN,
  output logic                DISPENSE,
  output logic [3:0]          DISPENSE_ID,
  output logic                CHANGE_VALID,
  output logic [CREDIT_W-1:0] CHANGE_AMT,
  output logic                COIN_REJECT,
  output logic                NO_STOCK,
  output logic [CREDIT_W-1:0] CREDIT,
  output logic [2:0]          STATE_OUT
);

  localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [4:0] NUM_PROD_L = 5'(NUM_PROD);

  logic [BTN_NUM-1:0] btn_lvl, btn_p;

  assign btn_lvl = {BTN_CANCEL, BTN_BUY, BTN_L, BTN_U, BTN_D, BTN_R};

  btn_edge_detect #(.W(BTN_NUM)) u_btn_edge (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .btn_i   (btn_lvl),
    .pulse_o (btn_p)
  );

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] price_q, price_d;
  logic [3:0]          id_q, id_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [1:0]          dir_q, dir_d;
  logic                nav_en_q, nav_en_d;
  logic                disp_q, disp_d;
  logic [3:0]          disp_id_q, disp_id_d;
  logic                chg_valid_q, chg_valid_d;
  logic [CREDIT_W-1:0] chg_amt_q, chg_amt_d;
  logic                reject_q, reject_d;
  logic                nostock_q, nostock_d;

  logic                dir_p;
  logic [1:0]          dir_code;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_ok;
  logic                stock_avail;
  logic [CREDIT_W-1:0] change_calc;

  always_comb begin
    dir_p    = btn_p[BTN_IDX_L] | btn_p[BTN_IDX_U] | btn_p[BTN_IDX_D] | btn_p[BTN_IDX_R];
    dir_code = DIR_RIGHT;
    if (btn_p[BTN_IDX_L])      dir_code = DIR_LEFT;
    else if (btn_p[BTN_IDX_U]) dir_code = DIR_UP;
    else if (btn_p[BTN_IDX_D]) dir_code = DIR_DOWN;
  end

  // IDs outside the product range are treated as unavailable.
  assign stock_avail = STOCK_OK && ({1'b0, PRODUCT_ID} < NUM_PROD_L);

  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    price_d     = price_q;
    id_d        = id_q;
    tmo_d       = tmo_q;
    dir_d       = dir_q;
    nav_en_d    = 1'b0;
    disp_d      = 1'b0;
    disp_id_d   = '0;
    chg_valid_d = 1'b0;
    chg_amt_d   = '0;
    reject_d    = 1'b0;
    nostock_d   = 1'b0;
    coin_ok     = 1'b0;
    change_calc = '0;
    coin_sum    = {1'b0, credit_q} + {1'b0, COIN_VALUE};

    if (COIN_VALID) begin
      if ((state_q == ST_IDLE || state_q == ST_PAY) && !coin_sum[CREDIT_W]) begin
        credit_d = coin_sum[CREDIT_W-1:0];
        coin_ok  = 1'b1;
      end else begin
        reject_d = 1'b1;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (btn_p[BTN_IDX_CANCEL]) begin
          if (credit_q != '0) state_d = ST_REFUND;
        end else if (btn_p[BTN_IDX_BUY]) begin
          if (!stock_avail) begin
            nostock_d = 1'b1;
          end else begin
            id_d    = PRODUCT_ID;
            price_d = PRICE;
            tmo_d   = '0;
            // Sufficiency uses pre-coin credit; a same-cycle coin completes PAY next cycle.
            state_d = (credit_q >= PRICE) ? ST_DISPENSE : ST_PAY;
          end
        end else if (dir_p) begin
          nav_en_d = 1'b1;
          dir_d    = dir_code;
        end
      end
      ST_PAY: begin
        if (credit_q >= price_q)                 state_d = ST_DISPENSE;
        else if (btn_p[BTN_IDX_CANCEL])          state_d = ST_REFUND;
        else if (coin_ok)                        tmo_d   = '0;
        else if (tmo_q == TMO_LAST)              state_d = ST_REFUND;
        else                                     tmo_d   = tmo_q + TMO_W'(1);
      end
      ST_DISPENSE: state_d = ST_CHANGE;
      ST_CHANGE: begin
        credit_d = '0;
        state_d  = ST_IDLE;
      end
      ST_REFUND: begin
        credit_d = '0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobes are keyed to the state being entered so they coincide with STATE_OUT.
    if (state_d == ST_DISPENSE) begin
      disp_d    = 1'b1;
      disp_id_d = id_d;
    end
    if (state_d == ST_CHANGE) begin
      change_calc = credit_d - price_d;
      chg_amt_d   = change_calc;
      chg_valid_d = (change_calc != '0);
    end
    if (state_d == ST_REFUND) begin
      chg_amt_d   = credit_d;
      chg_valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      credit_q    <= '0;
      price_q     <= '0;
      id_q        <= '0;
      tmo_q       <= '0;
      dir_q       <= '0;
      nav_en_q    <= 1'b0;
      disp_q      <= 1'b0;
      disp_id_q   <= '0;
      chg_valid_q <= 1'b0;
      chg_amt_q   <= '0;
      reject_q    <= 1'b0;
      nostock_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      price_q     <= price_d;
      id_q        <= id_d;
      tmo_q       <= tmo_d;
      dir_q       <= dir_d;
      nav_en_q    <= nav_en_d;
      disp_q      <= disp_d;
      disp_id_q   <= disp_id_d;
      chg_valid_q <= chg_valid_d;
      chg_amt_q   <= chg_amt_d;
      reject_q    <= reject_d;
      nostock_q   <= nostock_d;
    end
  end

  assign DIR_OUT      = dir_q;
  assign NAV_EN       = nav_en_q;
  assign DISPENSE     = disp_q;
  assign DISPENSE_ID  = disp_id_q;
  assign CHANGE_VALID = chg_valid_q;
  assign CHANGE_AMT   = chg_amt_q;
  assign COIN_REJECT  = reject_q;
  assign NO_STOCK     = nostock_q;
  assign CREDIT       = credit_q;
  assign STATE_OUT    = state_q;

endmodule

// File: tb/tb_sale_sequencer.sv
// Directed bench for sale_sequencer: navigation arbitration, purchase, pay/timeout, coin
// saturation, no-stock and mid-transaction reset, all with hand-computed expectations.
module tb_sale_sequencer;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PAY  = 3'd1;
  localparam logic [2:0] S_DISP = 3'd2;
  localparam logic [2:0] S_CHG  = 3'd3;
  localparam logic [2:0] S_REF  = 3'd4;

  logic       CLOCK = 1'b0;
  logic       RESET_N;
  logic       BTN_L, BTN_U, BTN_D, BTN_R, BTN_BUY, BTN_CANCEL;
  logic       COIN_VALID;
  logic [7:0] COIN_VALUE;
  logic [3:0] PRODUCT_ID;
  logic [7:0] PRICE;
  logic       STOCK_OK;
  logic [1:0] DIR_OUT;
  logic       NAV_EN, DISPENSE, CHANGE_VALID, COIN_REJECT, NO_STOCK;
  logic [3:0] DISPENSE_ID;
  logic [7:0] CHANGE_AMT, CREDIT;
  logic [2:0] STATE_OUT;

  int checks   = 0;
  int failures = 0;

  sale_sequencer #(.CREDIT_W(8), .TIMEOUT_CYC(16), .NUM_PROD(12)) dut (
    .CLOCK        (CLOCK),
    .RESET_N      (RESET_N),
    .BTN_L        (BTN_L),
    .BTN_U        (BTN_U),
    .BTN_D        (BTN_D),
    .BTN_R        (BTN_R),
    .BTN_BUY      (BTN_BUY),
    .BTN_CANCEL   (BTN_CANCEL),
    .COIN_VALID   (COIN_VALID),
    .COIN_VALUE   (COIN_VALUE),
    .PRODUCT_ID   (PRODUCT_ID),
    .PRICE        (PRICE),
    .STOCK_OK     (STOCK_OK),
    .DIR_OUT      (DIR_OUT),
    .NAV_EN       (NAV_EN),
    .DISPENSE     (DISPENSE),
    .DISPENSE_ID  (DISPENSE_ID),
    .CHANGE_VALID (CHANGE_VALID),
    .CHANGE_AMT   (CHANGE_AMT),
    .COIN_REJECT  (COIN_REJECT),
    .NO_STOCK     (NO_STOCK),
    .CREDIT       (CREDIT),
    .STATE_OUT    (STATE_OUT)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  task automatic coin(input logic [7:0] v);
    COIN_VALID = 1'b1;
    COIN_VALUE = v;
    tick(1);
    COIN_VALID = 1'b0;
    COIN_VALUE = 8'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b0;
    {BTN_L, BTN_U, BTN_D, BTN_BUY, BTN_CANCEL} = '0;
    BTN_R = 1'b1;
    COIN_VALID = 1'b0;
    COIN_VALUE = 8'd0;
    PRODUCT_ID = 4'd0;
    PRICE      = 8'd0;
    STOCK_OK   = 1'b1;

    // Reset with R held; R kept high afterwards must not navigate.
    tick(2);
    chk("rst_state", 32'(STATE_OUT), 32'(S_IDLE));
    chk("rst_outs", 32'({DIR_OUT, NAV_EN, DISPENSE, DISPENSE_ID, CHANGE_VALID, CHANGE_AMT,
                         COIN_REJECT, NO_STOCK, CREDIT}), 32'd0);
    RESET_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("held_r_no_nav", 32'(NAV_EN), 32'd0);
    end
    BTN_R = 1'b0;
    tick(1);

    // R then U on consecutive cycles.
    BTN_R = 1'b1;
    tick(1);
    BTN_U = 1'b1;
    tick(1);
    chk("nav_r_en", 32'(NAV_EN), 32'd1);
    chk("nav_r_dir", 32'(DIR_OUT), 32'd3);
    tick(1);
    chk("nav_u_en", 32'(NAV_EN), 32'd1);
    chk("nav_u_dir", 32'(DIR_OUT), 32'd1);
    BTN_R = 1'b0;
    BTN_U = 1'b0;
    tick(1);
    chk("nav_idle_en", 32'(NAV_EN), 32'd0);
    chk("dir_hold", 32'(DIR_OUT), 32'd1);

    // L and R together: only left.
    BTN_L = 1'b1;
    BTN_R = 1'b1;
    tick(2);
    chk("nav_lr_en", 32'(NAV_EN), 32'd1);
    chk("nav_lr_dir", 32'(DIR_OUT), 32'd0);
    tick(1);
    chk("nav_lr_single", 32'(NAV_EN), 32'd0);
    BTN_L = 1'b0;
    BTN_R = 1'b0;
    tick(1);

    // 5+5 credit, buy price 7 -> dispense ID 3, change 3.
    PRODUCT_ID = 4'd3;
    PRICE      = 8'd7;
    coin(8'd5);
    chk("credit_5", 32'(CREDIT), 32'd5);
    coin(8'd5);
    chk("credit_10", 32'(CREDIT), 32'd10);
    BTN_BUY = 1'b1;
    tick(2);
    chk("buy_disp_state", 32'(STATE_OUT), 32'(S_DISP));
    chk("buy_disp", 32'(DISPENSE), 32'd1);
    chk("buy_disp_id", 32'(DISPENSE_ID), 32'd3);
    BTN_BUY = 1'b0;
    tick(1);
    chk("chg_state", 32'(STATE_OUT), 32'(S_CHG));
    chk("chg_valid", 32'(CHANGE_VALID), 32'd1);
    chk("chg_amt", 32'(CHANGE_AMT), 32'd3);
    chk("chg_disp_off", 32'(DISPENSE), 32'd0);
    tick(1);
    chk("after_chg_state", 32'(STATE_OUT), 32'(S_IDLE));
    chk("after_chg_credit", 32'(CREDIT), 32'd0);
    chk("after_chg_valid", 32'(CHANGE_VALID), 32'd0);

    // Buy price 20 with no credit -> PAY; navigation blocked; coin 20 completes, no change.
    PRODUCT_ID = 4'd5;
    PRICE      = 8'd20;
    BTN_BUY = 1'b1;
    tick(2);
    chk("pay_state", 32'(STATE_OUT), 32'(S_PAY));
    BTN_BUY = 1'b0;
    BTN_D   = 1'b1;
    tick(2);
    chk("pay_no_nav_a", 32'(NAV_EN), 32'd0);
    tick(1);
    chk("pay_no_nav_b", 32'(NAV_EN), 32'd0);
    BTN_D = 1'b0;
    PRICE = 8'd99;
    coin(8'd20);
    chk("pay_credit_20", 32'(CREDIT), 32'd20);
    chk("pay_still", 32'(STATE_OUT), 32'(S_PAY));
    tick(1);
    chk("pay_disp_state", 32'(STATE_OUT), 32'(S_DISP));
    chk("pay_disp_id", 32'(DISPENSE_ID), 32'd5);
    tick(1);
    chk("pay_chg_state", 32'(STATE_OUT), 32'(S_CHG));
    chk("pay_no_change", 32'(CHANGE_VALID), 32'd0);
    tick(1);
    chk("pay_done_credit", 32'(CREDIT), 32'd0);

    // Credit 6, PAY timeout after 16 idle cycles -> refund 6.
    PRICE = 8'd20;
    coin(8'd6);
    BTN_BUY = 1'b1;
    tick(2);
    chk("tmo_pay_entry", 32'(STATE_OUT), 32'(S_PAY));
    BTN_BUY = 1'b0;
    tick(15);
    chk("tmo_not_yet", 32'(STATE_OUT), 32'(S_PAY));
    tick(1);
    chk("tmo_refund_state", 32'(STATE_OUT), 32'(S_REF));
    chk("tmo_refund_valid", 32'(CHANGE_VALID), 32'd1);
    chk("tmo_refund_amt", 32'(CHANGE_AMT), 32'd6);
    tick(1);
    chk("tmo_idle", 32'(STATE_OUT), 32'(S_IDLE));
    chk("tmo_credit0", 32'(CREDIT), 32'd0);

    // Coin 250 on credit 10 overflows -> rejected; then cancel refunds 10.
    coin(8'd10);
    coin(8'd250);
    chk("ovf_reject", 32'(COIN_REJECT), 32'd1);
    chk("ovf_credit", 32'(CREDIT), 32'd10);
    tick(1);
    chk("ovf_reject_1cyc", 32'(COIN_REJECT), 32'd0);
    BTN_CANCEL = 1'b1;
    tick(2);
    chk("cancel_refund", 32'(STATE_OUT), 32'(S_REF));
    chk("cancel_amt", 32'(CHANGE_AMT), 32'd10);
    BTN_CANCEL = 1'b0;
    tick(1);
    chk("cancel_credit0", 32'(CREDIT), 32'd0);

    // Out of stock, and an out-of-range product ID.
    STOCK_OK = 1'b0;
    BTN_BUY  = 1'b1;
    tick(2);
    chk("nostock_pulse", 32'(NO_STOCK), 32'd1);
    chk("nostock_idle", 32'(STATE_OUT), 32'(S_IDLE));
    BTN_BUY = 1'b0;
    tick(1);
    chk("nostock_1cyc", 32'(NO_STOCK), 32'd0);
    STOCK_OK   = 1'b1;
    PRODUCT_ID = 4'd13;
    BTN_BUY    = 1'b1;
    tick(2);
    chk("badid_nostock", 32'(NO_STOCK), 32'd1);
    BTN_BUY = 1'b0;
    tick(1);

    // Reset in PAY with credit 9 discards credit silently.
    PRODUCT_ID = 4'd2;
    coin(8'd9);
    BTN_BUY = 1'b1;
    tick(2);
    chk("rstpay_state", 32'(STATE_OUT), 32'(S_PAY));
    chk("rstpay_credit", 32'(CREDIT), 32'd9);
    BTN_BUY = 1'b0;
    RESET_N = 1'b0;
    tick(1);
    chk("rstpay_idle", 32'(STATE_OUT), 32'(S_IDLE));
    chk("rstpay_credit0", 32'(CREDIT), 32'd0);
    chk("rstpay_no_strobe", 32'(CHANGE_VALID), 32'd0);
    RESET_N = 1'b1;
    tick(1);
    chk("rstpay_after", 32'({STATE_OUT, CHANGE_VALID}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
